// File: rtl/run_length_decoder.sv
`default_nettype none
// ============================================================================
// Module   : run_length_decoder
// Purpose  : Expands (code, run_length) pairs into a per-cycle stream of
//            codes. Each pair is accepted on a valid/ready handshake. Its code
//            is then emitted run_length times on a valid/ready output.
//            Consecutive runs follow each other with no bubble cycle.
// Ports    : clk, reset (async, active-high)
//            in_valid / in_ready / in_code / in_len  - compressed pair input
//            out_valid / out_ready / out_code / out_last - expanded stream
//            busy          - run in progress (same as out_valid)
//            clear         - sync clear of sym_count and zero_len_err
//            sym_count     - saturating count of symbols handed off
//            zero_len_err  - sticky flag: a zero-length pair was accepted
// Revision : 1.0 - initial release
// ============================================================================
module run_length_decoder #(
    parameter int CODE_W = 4,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [LEN_W-1:0]  in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              busy,
    input  logic              clear,
    output logic [CNT_W-1:0]  sym_count,
    output logic              zero_len_err
);

    localparam logic [LEN_W-1:0] C_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_LEN_ZERO = '0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q,  code_d;
    logic              last_q,  last_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              zerr_q,  zerr_d;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_rem_is_one;
    logic              w_cnt_max;
    logic [LEN_W-1:0]  w_rem_dec;

    assign w_rem_is_one = (rem_q == C_LEN_ONE);
    assign w_rem_dec    = rem_q - C_LEN_ONE;
    assign w_cnt_max    = &cnt_q;

    // A new pair is taken when idle. It is also taken on the final symbol of
    // a run if that symbol is consumed this cycle, which gives bubble-free
    // chaining. This is the only combinational input-to-output path.
    assign in_ready   = (state_q == ST_IDLE) ||
                        ((state_q == ST_EXPAND) && w_rem_is_one && out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign out_valid    = (state_q == ST_EXPAND);
    assign busy         = out_valid;
    assign out_code     = code_q;
    assign out_last     = last_q;
    assign sym_count    = cnt_q;
    assign zero_len_err = zerr_q;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        zerr_d  = zerr_q;

        // Advance the current run. When no new pair is loaded below, the
        // final symbol returns the decoder to IDLE.
        if (w_out_fire) begin
            if (!w_rem_is_one) begin
                rem_d  = w_rem_dec;
                last_d = (w_rem_dec == C_LEN_ONE);
            end else begin
                state_d = ST_IDLE;
                rem_d   = C_LEN_ZERO;
                last_d  = 1'b0;
            end
        end

        // In EXPAND, in_fire can only occur together with the final out_fire.
        // A non-empty pair therefore overrides the IDLE transition above.
        if (w_in_fire) begin
            if (in_len != C_LEN_ZERO) begin
                state_d = ST_EXPAND;
                code_d  = in_code;
                rem_d   = in_len;
                last_d  = (in_len == C_LEN_ONE);
            end else begin
                zerr_d  = 1'b1;
            end
        end

        if (clear) begin
            cnt_d  = '0;
            zerr_d = 1'b0;
        end else if (w_out_fire && !w_cnt_max) begin
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            last_q  <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            zerr_q  <= zerr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_length_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_run_length_decoder
// Purpose  : Directed self-checking bench for run_length_decoder. A second
//            instance with a 4-bit statistics counter shares the same stimulus
//            so that counter saturation can be observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_run_length_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_code;
    logic [3:0] in_len;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_code;
    logic       out_last;
    logic       busy;
    logic       clear;
    logic [15:0] sym_count;
    logic       zero_len_err;

    logic       s_in_ready;
    logic       s_out_valid;
    logic [3:0] s_out_code;
    logic       s_out_last;
    logic       s_busy;
    logic [3:0] s_sym_count;
    logic       s_zero_len_err;

    int n_err    = 0;
    int n_checks = 0;
    int emitted;

    run_length_decoder #(.CODE_W(4), .LEN_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_last(out_last),
        .busy(busy), .clear(clear),
        .sym_count(sym_count), .zero_len_err(zero_len_err)
    );

    run_length_decoder #(.CODE_W(4), .LEN_W(4), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_code(in_code), .in_len(in_len),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_code(s_out_code), .out_last(s_out_last),
        .busy(s_busy), .clear(clear),
        .sym_count(s_sym_count), .zero_len_err(s_zero_len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after a rising edge; inputs change here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c, input logic [3:0] l);
        in_valid = 1'b1;
        in_code  = c;
        in_len   = l;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0;
        out_ready = 1'b0; clear = 1'b0;
        tick(); tick();
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_code", 32'(out_code), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_count", 32'(sym_count), 0);
        chk("rst_zerr", 32'(zero_len_err), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();

        // 1: single run (A,3)
        out_ready = 1'b1;
        send(4'hA, 4'd3);
        #1 chk("t1_in_ready_idle", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_code", 32'(out_code), 32'hA);
            chk("t1_last", 32'(out_last), 32'(i == 2));
            tick();
        end
        #1;
        chk("t1_done_valid", 32'(out_valid), 0);
        chk("t1_count", 32'(sym_count), 3);

        // 2: back-to-back (5,2),(9,1)
        send(4'h5, 4'd2);
        tick();
        send(4'h9, 4'd1);
        #1;
        chk("t2_s1_code", 32'(out_code), 5);
        chk("t2_s1_last", 32'(out_last), 0);
        chk("t2_s1_in_ready", 32'(in_ready), 0);
        tick();
        #1;
        chk("t2_s2_code", 32'(out_code), 5);
        chk("t2_s2_last", 32'(out_last), 1);
        chk("t2_s2_in_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t2_s3_valid", 32'(out_valid), 1);
        chk("t2_s3_code", 32'(out_code), 9);
        chk("t2_s3_last", 32'(out_last), 1);
        chk("t2_s3_in_ready", 32'(in_ready), 1);
        tick();
        #1;
        chk("t2_done_valid", 32'(out_valid), 0);
        chk("t2_count", 32'(sym_count), 6);

        // 3: (7,15) with out_ready toggling
        send(4'h7, 4'd15);
        tick();
        in_valid = 1'b0;
        emitted = 0;
        for (int k = 0; k < 40 && emitted < 15; k++) begin
            out_ready = (k % 2 == 0);
            #1;
            chk("t3_valid", 32'(out_valid), 1);
            chk("t3_code", 32'(out_code), 7);
            chk("t3_last", 32'(out_last), 32'(emitted == 14));
            chk("t3_in_ready", 32'(in_ready), 32'(out_ready && emitted == 14));
            if (out_ready) emitted++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t3_emitted", 32'(emitted), 15);
        chk("t3_done_valid", 32'(out_valid), 0);
        chk("t3_count", 32'(sym_count), 21);

        // 4: empty run, sticky error, then (4,2), then clear
        send(4'h3, 4'd0);
        tick();
        send(4'h4, 4'd2);
        #1;
        chk("t4_zero_no_symbol", 32'(out_valid), 0);
        chk("t4_zerr_set", 32'(zero_len_err), 1);
        chk("t4_count_hold", 32'(sym_count), 21);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t4_s1_code", 32'(out_code), 4);
        chk("t4_s1_last", 32'(out_last), 0);
        tick();
        #1;
        chk("t4_s2_code", 32'(out_code), 4);
        chk("t4_s2_last", 32'(out_last), 1);
        tick();
        #1;
        chk("t4_done_valid", 32'(out_valid), 0);
        chk("t4_zerr_sticky", 32'(zero_len_err), 1);
        chk("t4_count", 32'(sym_count), 23);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("t4_clear_zerr", 32'(zero_len_err), 0);
        chk("t4_clear_count", 32'(sym_count), 0);
        chk("t4_clear_in_ready", 32'(in_ready), 1);

        // 5: reset mid-run of (B,10) after 4 symbols
        send(4'hB, 4'd10);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("t5_mid_valid", 32'(out_valid), 1);
        chk("t5_mid_count", 32'(sym_count), 4);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_count", 32'(sym_count), 0);
        chk("t5_rst_code", 32'(out_code), 0);
        reset = 1'b0;
        tick();
        send(4'hC, 4'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_c_valid", 32'(out_valid), 1);
        chk("t5_c_code", 32'(out_code), 32'hC);
        chk("t5_c_last", 32'(out_last), 1);
        tick();
        #1;
        chk("t5_done_valid", 32'(out_valid), 0);
        chk("t5_count", 32'(sym_count), 1);

        // 6: 19 more symbols (20 total); 4-bit counter saturates at 15
        send(4'hF, 4'd15);
        tick();
        send(4'h6, 4'd4);
        repeat (15) tick();
        in_valid = 1'b0;
        #1;
        chk("t6_chain_code", 32'(out_code), 6);
        chk("t6_chain_last", 32'(out_last), 0);
        repeat (4) tick();
        #1;
        chk("t6_done_valid", 32'(out_valid), 0);
        chk("t6_count16", 32'(sym_count), 20);
        chk("t6_count4_sat", 32'(s_sym_count), 15);
        send(4'h2, 4'd2);
        tick();
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("t6_clear_prio16", 32'(sym_count), 0);
        chk("t6_clear_prio4", 32'(s_sym_count), 0);
        chk("t6_clear_keeps_run", 32'(out_valid), 1);
        tick();
        #1;
        chk("t6_after_count16", 32'(sym_count), 1);
        chk("t6_after_count4", 32'(s_sym_count), 1);
        chk("t6_after_valid", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
